// File: rtl/mmio_uart_ctrl.sv
// MMIO bridge between the CPU data port and the UART: one-entry RX/TX buffers,
// registered read data, and the cycle / retired-instruction counters.
module mmio_uart_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmio_addr,
  input  logic        mmio_we,
  input  logic        mmio_re,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic        inst_retired,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_RX_DATA = 8'h04;
  localparam logic [7:0] OFF_TX_DATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE   = 8'h10;
  localparam logic [7:0] OFF_INST    = 8'h14;
  localparam logic [7:0] OFF_CNT_RST = 8'h18;

  logic                 hit;
  logic [7:0]           offset;
  logic                 rd;
  logic                 wr;
  logic                 rx_full;
  logic [7:0]           rx_buf;
  logic                 tx_full;
  logic [7:0]           tx_buf;
  logic                 tx_overflow;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic [31:0]          cycle_ext;
  logic [31:0]          inst_ext;
  logic [31:0]          rd_mux;
  logic                 rx_take;
  logic                 rx_pop;
  logic                 tx_store;
  logic                 tx_hs;
  logic                 ctrl_rd;
  logic                 cnt_clr;
  logic                 unused_wdata;

  assign hit    = (mmio_addr[31:8] == ADDR_BASE[31:8]);
  assign offset = mmio_addr[7:0];
  assign rd     = hit && mmio_re;
  assign wr     = hit && mmio_we;

  assign rx_take  = uart_rx_valid && !rx_full;
  assign rx_pop   = rd && (offset == OFF_RX_DATA) && rx_full;
  assign tx_store = wr && (offset == OFF_TX_DATA);
  assign tx_hs    = tx_full && uart_tx_ready;
  assign ctrl_rd  = rd && (offset == OFF_CTRL);
  assign cnt_clr  = wr && (offset == OFF_CNT_RST);

  assign uart_rx_ready = !rx_full;
  assign uart_tx_valid = tx_full;
  assign uart_tx_data  = tx_buf;

  // Only the low byte of store data is ever consumed.
  assign unused_wdata = ^mmio_wdata[31:8];

  always_comb begin
    cycle_ext = '0;
    inst_ext  = '0;
    cycle_ext[CNT_WIDTH-1:0] = cycle_cnt;
    inst_ext[CNT_WIDTH-1:0]  = inst_cnt;
  end

  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_CTRL:    rd_mux = {29'd0, tx_overflow, rx_full, !tx_full};
      OFF_RX_DATA: rd_mux = {24'd0, rx_buf};
      OFF_CYCLE:   rd_mux = cycle_ext;
      OFF_INST:    rd_mux = inst_ext;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_rdata <= '0;
    end else if (rd) begin
      mmio_rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_full <= 1'b0;
      rx_buf  <= '0;
    end else if (rx_take) begin
      rx_full <= 1'b1;
      rx_buf  <= uart_rx_data;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  // A store is accepted when the holding register is empty or drains this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_full     <= 1'b0;
      tx_buf      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_store && (!tx_full || tx_hs)) begin
        tx_full <= 1'b1;
        tx_buf  <= mmio_wdata[7:0];
      end else if (tx_hs) begin
        tx_full <= 1'b0;
      end

      if (tx_store && tx_full && !tx_hs) begin
        tx_overflow <= 1'b1;
      end else if (ctrl_rd) begin
        tx_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (inst_retired) begin
        inst_cnt <= inst_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl; read expectations go through a scoreboard queue.
module tb_mmio_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mmio_addr;
  logic        mmio_we;
  logic        mmio_re;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        inst_retired;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  logic [31:0] rdata4;
  logic [7:0]  tx_data4;
  logic        tx_valid4;
  logic        rx_ready4;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] exp4_q[$];

  localparam logic [31:0] A_CTRL  = 32'h8000_0000;
  localparam logic [31:0] A_RX    = 32'h8000_0004;
  localparam logic [31:0] A_TX    = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE = 32'h8000_0010;
  localparam logic [31:0] A_INST  = 32'h8000_0014;
  localparam logic [31:0] A_CRST  = 32'h8000_0018;

  always #5 clk = ~clk;

  mmio_uart_ctrl #(.ADDR_BASE(32'h8000_0000), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_we(mmio_we),
    .mmio_re(mmio_re), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
    .inst_retired(inst_retired), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready)
  );

  mmio_uart_ctrl #(.ADDR_BASE(32'h8000_0000), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .mmio_addr(mmio_addr), .mmio_we(mmio_we),
    .mmio_re(mmio_re), .mmio_wdata(mmio_wdata), .mmio_rdata(rdata4),
    .inst_retired(inst_retired), .uart_tx_data(tx_data4),
    .uart_tx_valid(tx_valid4), .uart_tx_ready(uart_tx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(rx_ready4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mmio_write(input logic [31:0] addr, input logic [31:0] data);
    mmio_addr  = addr;
    mmio_wdata = data;
    mmio_we    = 1'b1;
    cyc();
    mmio_we    = 1'b0;
  endtask

  task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    mmio_addr = addr;
    mmio_re   = 1'b1;
    cyc();
    mmio_re   = 1'b0;
    check(tag_q.pop_front(), mmio_rdata, exp_q.pop_front());
  endtask

  initial begin
    logic [9:0] pat;
    rst = 1'b1;
    mmio_addr = '0;
    mmio_we = 1'b0;
    mmio_re = 1'b0;
    mmio_wdata = '0;
    inst_retired = 1'b0;
    uart_tx_ready = 1'b0;
    uart_rx_data = '0;
    uart_rx_valid = 1'b0;
    repeat (5) cyc();

    check("rst_rdata", mmio_rdata, 32'h0);
    check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'h1);
    check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'h0);
    check("rst_tx_data", {24'd0, uart_tx_data}, 32'h0);
    rst = 1'b0;
    read_chk(A_CYCLE, 32'h0, "rst_cycle");
    read_chk(A_INST, 32'h0, "rst_inst");
    read_chk(A_CTRL, 32'h1, "rst_ctrl");

    // RX capture, then a byte offered while full must be refused
    uart_rx_data = 8'h5A;
    uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    check("rx_ready_full", {31'd0, uart_rx_ready}, 32'h0);
    uart_rx_data = 8'h77;
    uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    read_chk(A_CTRL, 32'h3, "rx_ctrl_full");
    check("rx_ready_hold", {31'd0, uart_rx_ready}, 32'h0);
    read_chk(A_RX, 32'h5A, "rx_data");
    check("rx_ready_pop", {31'd0, uart_rx_ready}, 32'h1);
    read_chk(A_CTRL, 32'h1, "rx_ctrl_empty");

    // TX overflow and sticky flag cleared by a CTRL read
    uart_tx_ready = 1'b0;
    mmio_write(A_TX, 32'h0000_0041);
    mmio_write(A_TX, 32'hFFFF_FF42);
    check("tx_data_first", {24'd0, uart_tx_data}, 32'h41);
    check("tx_valid_full", {31'd0, uart_tx_valid}, 32'h1);
    read_chk(A_CTRL, 32'h4, "tx_ovf_ctrl");
    read_chk(A_CTRL, 32'h0, "tx_ovf_clr");
    uart_tx_ready = 1'b1;
    cyc();
    uart_tx_ready = 1'b0;
    check("tx_valid_drain", {31'd0, uart_tx_valid}, 32'h0);
    read_chk(A_CTRL, 32'h1, "tx_ctrl_empty");

    // Store that coincides with the draining handshake
    mmio_write(A_TX, 32'h0000_0044);
    mmio_addr = A_TX;
    mmio_wdata = 32'h0000_0043;
    mmio_we = 1'b1;
    uart_tx_ready = 1'b1;
    cyc();
    mmio_we = 1'b0;
    uart_tx_ready = 1'b0;
    check("tx_same_edge_data", {24'd0, uart_tx_data}, 32'h43);
    check("tx_same_edge_valid", {31'd0, uart_tx_valid}, 32'h1);
    read_chk(A_CTRL, 32'h0, "tx_same_edge_ctrl");
    uart_tx_ready = 1'b1;
    cyc();
    uart_tx_ready = 1'b0;

    // Counters
    mmio_write(A_CRST, 32'h0);
    pat = 10'b1011011011;
    for (int i = 0; i < 10; i++) begin
      inst_retired = pat[i];
      cyc();
    end
    inst_retired = 1'b0;
    read_chk(A_INST, 32'd7, "inst_cnt");
    mmio_write(A_CRST, 32'h1234_5678);
    cyc();
    read_chk(A_CYCLE, 32'd1, "cycle_after_clr");
    read_chk(A_INST, 32'd0, "inst_after_clr");

    mmio_write(A_CRST, 32'h0);
    repeat (17) cyc();
    exp4_q.push_back(32'd1);
    exp_q.push_back(32'd17);
    mmio_addr = A_CYCLE;
    mmio_re = 1'b1;
    cyc();
    mmio_re = 1'b0;
    check("cycle_17", mmio_rdata, exp_q.pop_front());
    check("cycle_wrap4", rdata4, exp4_q.pop_front());

    // Decode edges
    read_chk(A_CTRL, 32'h1, "ctrl_before_miss");
    read_chk(32'h9000_0000, 32'h1, "miss_hold");
    read_chk(32'h8000_000C, 32'h0, "unmapped");
    mmio_write(32'h9000_0008, 32'h99);
    check("miss_write", {31'd0, uart_tx_valid}, 32'h0);
    read_chk(A_RX, 32'h5A, "rx_stale");
    read_chk(A_CTRL, 32'h1, "rx_stale_ctrl");

    // Reset while a TX byte is pending
    mmio_write(A_TX, 32'h55);
    check("tx_pending", {31'd0, uart_tx_valid}, 32'h1);
    rst = 1'b1;
    cyc();
    check("rst_mid_tx_valid", {31'd0, uart_tx_valid}, 32'h0);
    check("rst_mid_tx_data", {24'd0, uart_tx_data}, 32'h0);
    check("rst_mid_rdata", mmio_rdata, 32'h0);
    rst = 1'b0;
    read_chk(A_CTRL, 32'h1, "ctrl_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
